// File: rtl/joint_cmd_pkg.sv
// rtl/joint_cmd_pkg.sv - shared types and constants for the joint command scheduler
package joint_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] MODE_IDLE = 8'h00;

  localparam int MODE_W = 8;
  localparam int TGT_W  = 32;
  localparam int ID_W   = 32;
  localparam int CMD_W  = MODE_W + 3 * TGT_W + ID_W;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [TGT_W-1:0]  tgt_0;
    logic [TGT_W-1:0]  tgt_1;
    logic [TGT_W-1:0]  tgt_2;
    logic [ID_W-1:0]   id;
  } cmd_t;

endpackage

// File: rtl/joint_cmd_id_check.sv
// rtl/joint_cmd_id_check.sv - wrap-aware control ID filter for incoming commands
import joint_cmd_pkg::*;

module joint_cmd_id_check (
  input  logic            c,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [ID_W-1:0] cmd_control_id,
  output logic            accept,
  output logic            stale
);

  logic                   seen;
  logic [ID_W-1:0]        last_id;
  logic signed [ID_W-1:0] id_diff;

  // Modular difference: a positive signed result means "newer", even across the 2^32 wrap.
  assign id_diff = cmd_control_id - last_id;
  assign accept  = cmd_valid && (!seen || (id_diff > 0));
  assign stale   = cmd_valid && !accept;

  // Remember the newest accepted ID; only reset forgets it.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      seen    <= 1'b0;
      last_id <= '0;
    end else if (accept) begin
      seen    <= 1'b1;
      last_id <= cmd_control_id;
    end
  end

endmodule

// File: rtl/joint_cmd_sched.sv
// rtl/joint_cmd_sched.sv - holds one pending joint command and hands it to the loop on a tick
import joint_cmd_pkg::*;

module joint_cmd_sched #(
  parameter int TIMEOUT_TICKS = 1000,
  parameter int WD_W          = 16
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_mode,
  input  logic [31:0] cmd_tgt_0,
  input  logic [31:0] cmd_tgt_1,
  input  logic [31:0] cmd_tgt_2,
  input  logic [31:0] cmd_control_id,
  input  logic        tick,
  output logic        apply_valid,
  input  logic        apply_ready,
  output logic [7:0]  mode,
  output logic [31:0] tgt_0,
  output logic [31:0] tgt_1,
  output logic [31:0] tgt_2,
  output logic [31:0] active_id,
  output logic        timeout,
  output logic [15:0] stale_cnt,
  output logic [15:0] drop_cnt
);

  state_t          state, state_nxt;
  cmd_t            cmd_in, pend, act;
  logic            pend_full;
  logic            fault_load;
  logic            accept, stale;
  logic            xfer, wd_fire, ack;
  logic [WD_W-1:0] wd;

  assign cmd_in = '{mode: cmd_mode, tgt_0: cmd_tgt_0, tgt_1: cmd_tgt_1,
                    tgt_2: cmd_tgt_2, id: cmd_control_id};

  // A tick moves pending into the active slot from any state except LOAD.
  assign xfer    = tick && pend_full && (state != ST_LOAD);
  assign wd_fire = (state == ST_RUN) && tick && !pend_full &&
                   (wd == WD_W'(TIMEOUT_TICKS - 1));
  assign ack     = (state == ST_LOAD) && apply_ready;

  assign apply_valid = (state == ST_LOAD);
  assign mode        = act.mode;
  assign tgt_0       = act.tgt_0;
  assign tgt_1       = act.tgt_1;
  assign tgt_2       = act.tgt_2;
  assign active_id   = act.id;

  joint_cmd_id_check u_id_check (
    .c              (c),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_control_id (cmd_control_id),
    .accept         (accept),
    .stale          (stale)
  );

  // State register.
  always_ff @(posedge c) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: loads are entered by a transfer or a watchdog fire, left on acknowledge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (xfer) state_nxt = ST_LOAD;
      ST_LOAD:  if (apply_ready) state_nxt = fault_load ? ST_FAULT : ST_RUN;
      ST_RUN:   if (xfer || wd_fire) state_nxt = ST_LOAD;
      ST_FAULT: if (xfer) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pending slot: a same-cycle accept refills it even while it is being transferred.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (accept) pend <= cmd_in;
      pend_full <= accept || (pend_full && !xfer);
    end
  end

  // Active command, fault flag and tick watchdog.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      act        <= '0;
      fault_load <= 1'b0;
      timeout    <= 1'b0;
      wd         <= '0;
    end else begin
      if (xfer) begin
        act        <= pend;
        fault_load <= 1'b0;
      end else if (wd_fire) begin
        act        <= '{mode: MODE_IDLE, tgt_0: '0, tgt_1: '0, tgt_2: '0, id: '0};
        fault_load <= 1'b1;
        timeout    <= 1'b1;
      end
      if (ack) begin
        wd <= '0;
        if (!fault_load) timeout <= 1'b0;
      end else if ((state == ST_RUN) && tick && !pend_full && !wd_fire) begin
        wd <= wd + 1'b1;
      end
    end
  end

  // Saturating rejection and overwrite counters.
  always_ff @(posedge c) begin
    if (!rst_n) begin
      stale_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (stale && (stale_cnt != 16'hFFFF)) stale_cnt <= stale_cnt + 16'd1;
      if (accept && pend_full && !xfer && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_joint_cmd_sched.sv
// tb/tb_joint_cmd_sched.sv - self-checking bench for joint_cmd_sched
module tb_joint_cmd_sched;

  localparam int TO = 4;

  logic        c;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_mode;
  logic [31:0] cmd_tgt_0, cmd_tgt_1, cmd_tgt_2;
  logic [31:0] cmd_control_id;
  logic        tick;
  logic        apply_valid;
  logic        apply_ready;
  logic [7:0]  mode;
  logic [31:0] tgt_0, tgt_1, tgt_2;
  logic [31:0] active_id;
  logic        timeout;
  logic [15:0] stale_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  joint_cmd_sched #(.TIMEOUT_TICKS(TO), .WD_W(16)) dut (
    .c              (c),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_mode       (cmd_mode),
    .cmd_tgt_0      (cmd_tgt_0),
    .cmd_tgt_1      (cmd_tgt_1),
    .cmd_tgt_2      (cmd_tgt_2),
    .cmd_control_id (cmd_control_id),
    .tick           (tick),
    .apply_valid    (apply_valid),
    .apply_ready    (apply_ready),
    .mode           (mode),
    .tgt_0          (tgt_0),
    .tgt_1          (tgt_1),
    .tgt_2          (tgt_2),
    .active_id      (active_id),
    .timeout        (timeout),
    .stale_cnt      (stale_cnt),
    .drop_cnt       (drop_cnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    logic        cv;
    logic [31:0] id;
    logic [7:0]  md;
    logic [31:0] t0;
    logic        tk;
    logic        rdy;
    logic        e_av;
    logic [7:0]  e_md;
    logic [31:0] e_t0;
    logic [31:0] e_id;
    logic [15:0] e_st;
    logic [15:0] e_dr;
  } vec_t;

  vec_t tbl[14];

  typedef struct packed {
    logic [7:0]  md;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] id;
  } mcmd_t;

  // Reference model state
  logic        m_seen;
  logic [31:0] m_last;
  mcmd_t       pq[$];
  mcmd_t       m_out;
  logic        m_offer;
  logic        m_fault_offer;
  int          m_phase;
  int          m_wd;
  logic        m_to;
  int          m_stale;
  int          m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic cv, input logic [31:0] id, input logic [7:0] md,
                     input logic [31:0] t0, input logic tk, input logic rdy);
    cmd_valid      = cv;
    cmd_control_id = id;
    cmd_mode       = md;
    cmd_tgt_0      = t0;
    cmd_tgt_1      = t0 ^ 32'h1111;
    cmd_tgt_2      = ~t0;
    tick           = tk;
    apply_ready    = rdy;
    @(posedge c);
    #1;
    cmd_valid   = 1'b0;
    tick        = 1'b0;
    apply_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; tick = 1'b0; apply_ready = 1'b0;
    @(posedge c);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic av, input logic [7:0] md,
                         input logic [31:0] id, input logic to);
    chk({nm, "_av"}, 32'(apply_valid), 32'(av));
    chk({nm, "_mode"}, 32'(mode), 32'(md));
    chk({nm, "_id"}, active_id, id);
    chk({nm, "_to"}, 32'(timeout), 32'(to));
  endtask

  task automatic model_reset();
    m_seen = 1'b0; m_last = '0; pq.delete(); m_out = '0; m_offer = 1'b0;
    m_fault_offer = 1'b0; m_phase = 0; m_wd = 0; m_to = 1'b0; m_stale = 0; m_drop = 0;
  endtask

  // One cycle of the scheduling rules, evaluated from the state before the edge.
  task automatic model_step(input logic cv, input mcmd_t nc, input logic tk, input logic rdy);
    logic signed [31:0] d;
    logic acc;
    d   = nc.id - m_last;
    acc = cv && (!m_seen || d > 0);
    if (m_offer) begin
      if (rdy) begin
        m_offer = 1'b0;
        m_wd    = 0;
        if (m_fault_offer) m_phase = 2;
        else begin m_phase = 1; m_to = 1'b0; end
      end
    end else if (tk && pq.size() > 0) begin
      m_out = pq.pop_front();
      m_offer = 1'b1;
      m_fault_offer = 1'b0;
    end else if (tk && m_phase == 1) begin
      m_wd++;
      if (m_wd == TO) begin
        m_out = '0; m_offer = 1'b1; m_fault_offer = 1'b1; m_to = 1'b1;
      end
    end
    if (acc) begin
      m_seen = 1'b1;
      m_last = nc.id;
      if (pq.size() > 0) begin
        void'(pq.pop_front());
        if (m_drop < 65535) m_drop++;
      end
      pq.push_back(nc);
    end else if (cv) begin
      if (m_stale < 65535) m_stale++;
    end
  endtask

  initial begin
    logic        r_cv, r_tk, r_rdy;
    logic [31:0] r_id, r_t0;
    logic [7:0]  r_md;
    mcmd_t       nc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_tgt_0 = '0; cmd_tgt_1 = '0;
    cmd_tgt_2 = '0; cmd_control_id = '0; tick = 1'b0; apply_ready = 1'b0;

    tbl[0]  = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b0, 1'b0, 1'b0, 8'd0, 32'h0,   32'd0,  16'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'd5,  8'd2, 32'h100, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0,   32'd0,  16'd0, 16'd0};
    tbl[2]  = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b1, 1'b0, 1'b1, 8'd2, 32'h100, 32'd5,  16'd0, 16'd0};
    tbl[3]  = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b0, 1'b1, 1'b0, 8'd2, 32'h100, 32'd5,  16'd0, 16'd0};
    tbl[4]  = '{1'b1, 32'd10, 8'd3, 32'h200, 1'b0, 1'b0, 1'b0, 8'd2, 32'h100, 32'd5,  16'd0, 16'd0};
    tbl[5]  = '{1'b1, 32'd10, 8'd7, 32'h999, 1'b0, 1'b0, 1'b0, 8'd2, 32'h100, 32'd5,  16'd1, 16'd0};
    tbl[6]  = '{1'b1, 32'd9,  8'd7, 32'h999, 1'b0, 1'b0, 1'b0, 8'd2, 32'h100, 32'd5,  16'd2, 16'd0};
    tbl[7]  = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b1, 1'b0, 1'b1, 8'd3, 32'h200, 32'd10, 16'd2, 16'd0};
    tbl[8]  = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b0, 1'b1, 1'b0, 8'd3, 32'h200, 32'd10, 16'd2, 16'd0};
    tbl[9]  = '{1'b1, 32'd20, 8'd4, 32'h300, 1'b0, 1'b0, 1'b0, 8'd3, 32'h200, 32'd10, 16'd2, 16'd0};
    tbl[10] = '{1'b1, 32'd21, 8'd5, 32'h310, 1'b0, 1'b0, 1'b0, 8'd3, 32'h200, 32'd10, 16'd2, 16'd1};
    tbl[11] = '{1'b1, 32'd22, 8'd6, 32'h320, 1'b0, 1'b0, 1'b0, 8'd3, 32'h200, 32'd10, 16'd2, 16'd2};
    tbl[12] = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b1, 1'b0, 1'b1, 8'd6, 32'h320, 32'd22, 16'd2, 16'd2};
    tbl[13] = '{1'b0, 32'd0,  8'd0, 32'h0,   1'b0, 1'b1, 1'b0, 8'd6, 32'h320, 32'd22, 16'd2, 16'd2};

    @(posedge c); #1;
    do_reset();
    chk_out("reset", 1'b0, 8'd0, 32'd0, 1'b0);
    chk("reset_tgt1", tgt_1, 32'd0);
    chk("reset_tgt2", tgt_2, 32'd0);
    chk("reset_stale", 32'(stale_cnt), 32'd0);
    chk("reset_drop", 32'(drop_cnt), 32'd0);

    // Basic command, stale filtering and overwrite from the vector table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].cv, tbl[i].id, tbl[i].md, tbl[i].t0, tbl[i].tk, tbl[i].rdy);
      chk($sformatf("tbl%0d_av", i), 32'(apply_valid), 32'(tbl[i].e_av));
      chk($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].e_md));
      chk($sformatf("tbl%0d_tgt0", i), tgt_0, tbl[i].e_t0);
      chk($sformatf("tbl%0d_id", i), active_id, tbl[i].e_id);
      chk($sformatf("tbl%0d_stale", i), 32'(stale_cnt), 32'(tbl[i].e_st));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].e_dr));
      chk($sformatf("tbl%0d_to", i), 32'(timeout), 32'd0);
    end

    // Watchdog: three empty ticks are tolerated, the fourth forces a fault load
    for (int i = 0; i < TO - 1; i++) begin
      cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
      chk_out($sformatf("wd_tick%0d", i), 1'b0, 8'd6, 32'd22, 1'b0);
    end
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("wd_fire", 1'b1, 8'd0, 32'd0, 1'b1);
    chk("wd_fire_tgt0", tgt_0, 32'd0);
    chk("wd_fire_tgt1", tgt_1, 32'd0);
    chk("wd_fire_tgt2", tgt_2, 32'd0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("wd_load_tick", 1'b1, 8'd0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    chk_out("wd_ack", 1'b0, 8'd0, 32'd0, 1'b1);
    for (int i = 0; i < TO + 1; i++) begin
      cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
      chk_out($sformatf("fault_tick%0d", i), 1'b0, 8'd0, 32'd0, 1'b1);
    end
    cyc(1'b1, 32'd30, 8'd7, 32'h700, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("recover_load", 1'b1, 8'd7, 32'd30, 1'b1);
    chk("recover_tgt1", tgt_1, 32'h1611);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    chk_out("recover_ack", 1'b0, 8'd7, 32'd30, 1'b0);

    // Collision: accept coincides with the transferring tick, then a held handshake
    cyc(1'b1, 32'd40, 8'd8, 32'h800, 1'b0, 1'b0);
    cyc(1'b1, 32'd41, 8'd9, 32'h900, 1'b1, 1'b0);
    chk_out("coll_load", 1'b1, 8'd8, 32'd40, 1'b0);
    chk("coll_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
      chk_out($sformatf("hold%0d", i), 1'b1, 8'd8, 32'd40, 1'b0);
      chk($sformatf("hold%0d_tgt0", i), tgt_0, 32'h800);
    end
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    chk_out("coll_ack", 1'b0, 8'd8, 32'd40, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("coll_second", 1'b1, 8'd9, 32'd41, 1'b0);
    chk("coll_drop2", 32'(drop_cnt), 32'd2);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);

    // Reset in the middle of a handshake
    cyc(1'b1, 32'd50, 8'd10, 32'hA00, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("pre_rst_load", 1'b1, 8'd10, 32'd50, 1'b0);
    do_reset();
    chk_out("mid_rst", 1'b0, 8'd0, 32'd0, 1'b0);
    chk("mid_rst_stale", 32'(stale_cnt), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    cyc(1'b1, 32'd50, 8'd11, 32'hB00, 1'b0, 1'b0);
    chk("post_rst_stale", 32'(stale_cnt), 32'd0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("post_rst_load", 1'b1, 8'd11, 32'd50, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd50, 8'd12, 32'hC00, 1'b0, 1'b0);
    chk("equal_id_stale", 32'(stale_cnt), 32'd1);

    // ID wrap: 0xFFFFFFF0 followed by 5 is newer
    do_reset();
    cyc(1'b1, 32'hFFFF_FFF0, 8'd1, 32'h10, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("wrap_first", 1'b1, 8'd1, 32'hFFFF_FFF0, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd5, 8'd2, 32'h20, 1'b0, 1'b0);
    chk("wrap_stale", 32'(stale_cnt), 32'd0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b1, 1'b0);
    chk_out("wrap_second", 1'b1, 8'd2, 32'd5, 1'b0);
    cyc(1'b0, 32'd0, 8'd0, 32'd0, 1'b0, 1'b1);

    // Randomised traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        model_reset();
      end else begin
        r_cv  = ($urandom_range(0, 99) < 35);
        r_tk  = ($urandom_range(0, 99) < 30);
        r_rdy = ($urandom_range(0, 99) < 40);
        r_md  = 8'($urandom);
        r_t0  = $urandom;
        r_id  = ($urandom_range(0, 9) == 0) ? 32'($urandom)
                                            : m_last + 32'($urandom_range(0, 8)) - 32'd3;
        nc    = '{r_md, r_t0, r_t0 ^ 32'h1111, ~r_t0, r_id};
        model_step(r_cv, nc, r_tk, r_rdy);
        cyc(r_cv, r_id, r_md, r_t0, r_tk, r_rdy);
      end
      chk("rnd_av", 32'(apply_valid), 32'(m_offer));
      chk("rnd_mode", 32'(mode), 32'(m_out.md));
      chk("rnd_tgt0", tgt_0, m_out.t0);
      chk("rnd_tgt1", tgt_1, m_out.t1);
      chk("rnd_tgt2", tgt_2, m_out.t2);
      chk("rnd_id", active_id, m_out.id);
      chk("rnd_to", 32'(timeout), 32'(m_to));
      chk("rnd_stale", 32'(stale_cnt), 32'(m_stale));
      chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
